// File: rtl/ciq_pkg.sv
// Shared types for the age-matrix issue queue: entry record and index-width helper.
// Entry field widths follow the top-level OPCODE / PRF_WIDTH defaults.
package ciq_pkg;

  localparam int unsigned CIQ_OPCODE_W = 7;
  localparam int unsigned CIQ_PRF_W    = 6;

  typedef struct packed {
    logic [CIQ_OPCODE_W-1:0] op;
    logic [CIQ_PRF_W-1:0]    prs1;
    logic                    prs1_v;
    logic                    prs1_rdy;
    logic [CIQ_PRF_W-1:0]    prs2;
    logic                    prs2_v;
    logic                    prs2_rdy;
    logic [CIQ_PRF_W-1:0]    prd;
    logic                    prd_v;
  } ciq_entry_t;

  function automatic int unsigned ciq_idx_w(input int unsigned depth);
    return unsigned'($clog2(depth));
  endfunction

endpackage

// File: rtl/ciq_free_finder.sv
// Lowest-index free-entry finder: returns the DISPATCH_W lowest free indices
// (prefix-count over the free vector) and the total free popcount.
module ciq_free_finder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned IDX_W      = 4
) (
  input  logic [DEPTH-1:0]                 free_vec,
  output logic [DISPATCH_W-1:0][IDX_W-1:0] free_idx,
  output logic [DISPATCH_W-1:0]            free_idx_v,
  output logic [IDX_W:0]                   free_cnt
);

  logic [IDX_W:0] cnt;

  always_comb begin
    free_idx   = '0;
    free_idx_v = '0;
    cnt        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (free_vec[i]) begin
        for (int unsigned k = 0; k < DISPATCH_W; k++) begin
          if (cnt == (IDX_W+1)'(k)) begin
            free_idx[k]   = IDX_W'(i);
            free_idx_v[k] = 1'b1;
          end
        end
        cnt = cnt + (IDX_W+1)'(1);
      end
    end
  end

  assign free_cnt = cnt;

endmodule

// File: rtl/ciq_age_issue_queue.sv
// Centralised issue queue with age-matrix oldest-ready select.
// Optional `CIQ_ISSUE_WAKE_EN: the issuing entry's prd acts as an extra same-cycle wakeup.
module ciq_age_issue_queue
  import ciq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned WAKE_W     = 2,
  parameter int unsigned OPCODE     = CIQ_OPCODE_W,
  parameter int unsigned PRF_WIDTH  = CIQ_PRF_W,
  parameter int unsigned IDX_W      = ciq_idx_w(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [DISPATCH_W-1:0]           disp_v,
  input  logic [DISPATCH_W*OPCODE-1:0]    disp_op,
  input  logic [DISPATCH_W*PRF_WIDTH-1:0] disp_prs1,
  input  logic [DISPATCH_W*PRF_WIDTH-1:0] disp_prs2,
  input  logic [DISPATCH_W-1:0]           disp_prs1_v,
  input  logic [DISPATCH_W-1:0]           disp_prs2_v,
  input  logic [DISPATCH_W-1:0]           disp_prs1_rdy,
  input  logic [DISPATCH_W-1:0]           disp_prs2_rdy,
  input  logic [DISPATCH_W*PRF_WIDTH-1:0] disp_prd,
  input  logic [DISPATCH_W-1:0]           disp_prd_v,
  input  logic [WAKE_W-1:0]               wake_v,
  input  logic [WAKE_W*PRF_WIDTH-1:0]     wake_tag,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [OPCODE-1:0]               issue_op,
  output logic [PRF_WIDTH-1:0]            issue_prs1,
  output logic [PRF_WIDTH-1:0]            issue_prs2,
  output logic [PRF_WIDTH-1:0]            issue_prd,
  output logic                            issue_prd_v,
  output logic [IDX_W-1:0]                issue_idx,
  output logic [IDX_W:0]                  free_cnt
);

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0]                 age_q [DEPTH];
  logic [DEPTH-1:0]                 age_d [DEPTH];
  ciq_entry_t                       ent_q [DEPTH];
  ciq_entry_t                       new_ent [DISPATCH_W];
  logic [DISPATCH_W-1:0][IDX_W-1:0] fi_idx, slot_idx;
  logic [DISPATCH_W-1:0]            fi_idx_v, slot_en;
  logic [DEPTH-1:0]                 rdy, pick, alloc, grp;
  logic                             disp_fire, issue_fire, iw_v;
  logic [PRF_WIDTH-1:0]             iw_tag;

  ciq_free_finder #(.DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .IDX_W(IDX_W)) u_free (
    .free_vec  (~valid_q),
    .free_idx  (fi_idx),
    .free_idx_v(fi_idx_v),
    .free_cnt  (free_cnt)
  );

  assign disp_ready = (free_cnt >= (IDX_W+1)'(DISPATCH_W));
  assign disp_fire  = disp_valid & disp_ready;
  assign issue_fire = issue_valid & issue_ready;

`ifdef CIQ_ISSUE_WAKE_EN
  assign iw_v = issue_fire & issue_prd_v;
`else
  assign iw_v = 1'b0;
`endif
  assign iw_tag = issue_prd;

  function automatic logic tag_hit(input logic [PRF_WIDTH-1:0]        tag,
                                   input logic [WAKE_W-1:0]           wv,
                                   input logic [WAKE_W*PRF_WIDTH-1:0] wt,
                                   input logic                        xv,
                                   input logic [PRF_WIDTH-1:0]        xt);
    logic hit;
    hit = xv & (xt == tag);
    for (int unsigned w = 0; w < WAKE_W; w++)
      hit = hit | (wv[w] & (wt[w*PRF_WIDTH +: PRF_WIDTH] == tag));
    return hit;
  endfunction

  // Slot k takes the n-th free index, n = number of present slots below k.
  always_comb begin
    int unsigned n;
    n        = 0;
    slot_idx = '0;
    slot_en  = '0;
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      slot_idx[k] = fi_idx[n];
      slot_en[k]  = disp_v[k] & fi_idx_v[n];
      if (disp_v[k]) n = n + 1;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      new_ent[k].op       = disp_op[k*OPCODE +: OPCODE];
      new_ent[k].prs1     = disp_prs1[k*PRF_WIDTH +: PRF_WIDTH];
      new_ent[k].prs1_v   = disp_prs1_v[k];
      new_ent[k].prs1_rdy = disp_prs1_rdy[k] |
        tag_hit(disp_prs1[k*PRF_WIDTH +: PRF_WIDTH], wake_v, wake_tag, iw_v, iw_tag);
      new_ent[k].prs2     = disp_prs2[k*PRF_WIDTH +: PRF_WIDTH];
      new_ent[k].prs2_v   = disp_prs2_v[k];
      new_ent[k].prs2_rdy = disp_prs2_rdy[k] |
        tag_hit(disp_prs2[k*PRF_WIDTH +: PRF_WIDTH], wake_v, wake_tag, iw_v, iw_tag);
      new_ent[k].prd      = disp_prd[k*PRF_WIDTH +: PRF_WIDTH];
      new_ent[k].prd_v    = disp_prd_v[k];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy[i] = valid_q[i] & (~ent_q[i].prs1_v | ent_q[i].prs1_rdy)
                          & (~ent_q[i].prs2_v | ent_q[i].prs2_rdy);
    end
    for (int unsigned i = 0; i < DEPTH; i++)
      pick[i] = rdy[i] & ~|(age_q[i] & rdy);
  end

  assign issue_valid = |rdy;

  always_comb begin
    issue_op    = '0;
    issue_prs1  = '0;
    issue_prs2  = '0;
    issue_prd   = '0;
    issue_prd_v = 1'b0;
    issue_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pick[i]) begin
        issue_op    = issue_op    | ent_q[i].op;
        issue_prs1  = issue_prs1  | ent_q[i].prs1;
        issue_prs2  = issue_prs2  | ent_q[i].prs2;
        issue_prd   = issue_prd   | ent_q[i].prd;
        issue_prd_v = issue_prd_v | ent_q[i].prd_v;
        issue_idx   = issue_idx   | IDX_W'(i);
      end
    end
  end

  // Columns of newly allocated entries are cleared before their rows are written,
  // so intra-group ordering in the new rows survives.
  always_comb begin
    alloc = '0;
    grp   = '0;
    for (int unsigned k = 0; k < DISPATCH_W; k++)
      if (disp_fire && slot_en[k]) alloc[slot_idx[k]] = 1'b1;
    for (int unsigned r = 0; r < DEPTH; r++)
      age_d[r] = age_q[r] & ~alloc;
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      if (disp_fire && slot_en[k]) begin
        age_d[slot_idx[k]] = valid_q | grp;
        grp[slot_idx[k]]   = 1'b1;
      end
    end
    valid_d = valid_q | alloc;
    if (issue_fire) begin
      valid_d[issue_idx] = 1'b0;
      for (int unsigned r = 0; r < DEPTH; r++) age_d[r][issue_idx] = 1'b0;
    end
    if (flush) begin
      valid_d = '0;
      for (int unsigned r = 0; r < DEPTH; r++) age_d[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        age_q[r] <= '0;
        ent_q[r] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        age_q[r] <= age_d[r];
        if (ent_q[r].prs1_v && tag_hit(ent_q[r].prs1, wake_v, wake_tag, iw_v, iw_tag))
          ent_q[r].prs1_rdy <= 1'b1;
        if (ent_q[r].prs2_v && tag_hit(ent_q[r].prs2, wake_v, wake_tag, iw_v, iw_tag))
          ent_q[r].prs2_rdy <= 1'b1;
      end
      for (int unsigned k = 0; k < DISPATCH_W; k++)
        if (disp_fire && slot_en[k]) ent_q[slot_idx[k]] <= new_ent[k];
    end
  end

endmodule

// File: tb/tb_ciq_age_issue_queue.sv
// Directed bench for ciq_age_issue_queue (default DEPTH=16, DISPATCH_W=4, WAKE_W=2).
module tb_ciq_age_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready, issue_valid, issue_ready, issue_prd_v;
  logic [3:0]  disp_v, p1v, p2v, p1r, p2r, prdv;
  logic [27:0] disp_op;
  logic [23:0] disp_prs1, disp_prs2, disp_prd;
  logic [1:0]  wake_v;
  logic [11:0] wake_tag;
  logic [6:0]  issue_op;
  logic [5:0]  issue_prs1, issue_prs2, issue_prd;
  logic [3:0]  issue_idx;
  logic [4:0]  free_cnt;

  int n_chk = 0;
  int n_fail = 0;

  ciq_age_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_v(disp_v), .disp_op(disp_op), .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_prs1_v(p1v), .disp_prs2_v(p2v), .disp_prs1_rdy(p1r), .disp_prs2_rdy(p2r),
    .disp_prd(disp_prd), .disp_prd_v(prdv), .wake_v(wake_v), .wake_tag(wake_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_prs1(issue_prs1), .issue_prs2(issue_prs2), .issue_prd(issue_prd),
    .issue_prd_v(issue_prd_v), .issue_idx(issue_idx), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic iv, input int idx, input int fc,
                         input logic dr);
    chk({name, " issue_valid"}, 32'(issue_valid), 32'(iv));
    chk({name, " issue_idx"},   32'(issue_idx),   32'(idx));
    chk({name, " free_cnt"},    32'(free_cnt),    32'(fc));
    chk({name, " disp_ready"},  32'(disp_ready),  32'(dr));
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_v = '0; disp_op = '0;
    disp_prs1 = '0; disp_prs2 = '0; disp_prd = '0;
    p1v = '0; p2v = '0; p1r = '0; p2r = '0; prdv = '0;
    wake_v = '0; wake_tag = '0; issue_ready = 1'b0;
  endtask

  task automatic slot(input int k, input logic [6:0] op,
                      input logic [5:0] t1, input logic v1, input logic r1,
                      input logic [5:0] t2, input logic v2, input logic r2,
                      input logic [5:0] d, input logic dv);
    disp_op[k*7 +: 7] = op;
    disp_prs1[k*6 +: 6] = t1; p1v[k] = v1; p1r[k] = r1;
    disp_prs2[k*6 +: 6] = t2; p2v[k] = v2; p2r[k] = r2;
    disp_prd[k*6 +: 6] = d;   prdv[k] = dv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       dv;
    logic [3:0] mask;
    logic       ir;
    logic       exp_iv;
    int         exp_idx;
    int         exp_op;
    int         exp_free;
    logic       exp_dr;
  } vec_t;

  vec_t tv [6];

  initial begin
    tv[0] = '{1'b1, 4'hF, 1'b0, 1'b0, 0, 8'h00, 16, 1'b1};
    tv[1] = '{1'b0, 4'h0, 1'b1, 1'b1, 0, 8'h10, 12, 1'b1};
    tv[2] = '{1'b0, 4'h0, 1'b1, 1'b1, 1, 8'h11, 13, 1'b1};
    tv[3] = '{1'b0, 4'h0, 1'b1, 1'b1, 2, 8'h12, 14, 1'b1};
    tv[4] = '{1'b0, 4'h0, 1'b1, 1'b1, 3, 8'h13, 15, 1'b1};
    tv[5] = '{1'b0, 4'h0, 1'b0, 1'b0, 0, 8'h00, 16, 1'b1};

    idle();
    rst = 1'b1;
    repeat (2) tick();
    chk_out("reset", 1'b0, 0, 16, 1'b1);
    chk("reset issue_op", 32'(issue_op), 32'h0);
    rst = 1'b0;

    // Basic group dispatch then in-order drain, table driven
    for (int i = 0; i < 6; i++) begin
      chk_out($sformatf("t1[%0d]", i), tv[i].exp_iv, tv[i].exp_idx, tv[i].exp_free, tv[i].exp_dr);
      chk($sformatf("t1[%0d] issue_op", i), 32'(issue_op), 32'(tv[i].exp_op));
      idle();
      for (int k = 0; k < 4; k++) slot(k, 7'(16 + k), 6'h0, 0, 0, 6'h0, 0, 0, 6'(k), 1);
      disp_valid = tv[i].dv; disp_v = tv[i].mask; issue_ready = tv[i].ir;
      tick();
    end

    // Full queue: backpressure, hold, then refill behind older entries
    for (int g = 0; g < 4; g++) begin
      idle(); disp_valid = 1'b1; disp_v = 4'hF;
      for (int k = 0; k < 4; k++) slot(k, 7'(32 + 4*g + k), 6'h0, 0, 0, 6'h3F, 1, 0, 6'(k), 1);
      tick();
    end
    idle();
    chk_out("A full", 1'b0, 0, 0, 1'b0);
    disp_valid = 1'b1; disp_v = 4'hF;
    for (int k = 0; k < 4; k++) slot(k, 7'h50, 6'h0, 0, 0, 6'h0, 0, 0, 6'h0, 0);
    tick();
    chk_out("A held", 1'b0, 0, 0, 1'b0);
    wake_v = 2'b10; wake_tag[11:6] = 6'h3F;
    tick();
    wake_v = '0; issue_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk_out($sformatf("A drain%0d", j), 1'b1, j, j, 1'b0);
      tick();
    end
    chk_out("A reopen", 1'b1, 4, 4, 1'b1);
    issue_ready = 1'b0;
    tick();
    chk_out("A refill", 1'b1, 4, 0, 1'b0);
    chk("A refill issue_op", 32'(issue_op), 32'd36);
    idle(); flush = 1'b1; tick(); idle();
    chk_out("A flush", 1'b0, 0, 16, 1'b1);

    // Older entry woken late overtakes younger ready entries
    disp_valid = 1'b1; disp_v = 4'hF;
    slot(0, 7'h60, 6'h3F, 1, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(1, 7'h61, 6'h3F, 1, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(2, 7'h62, 6'h15, 1, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(3, 7'h63, 6'h3F, 1, 0, 6'h0, 0, 0, 6'h0, 0);
    tick();
    slot(0, 7'h64, 6'h3F, 1, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(1, 7'h65, 6'h00, 0, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(2, 7'h66, 6'h00, 1, 1, 6'h0, 0, 0, 6'h0, 0);
    slot(3, 7'h67, 6'h3F, 1, 0, 6'h0, 0, 0, 6'h0, 0);
    tick();
    idle();
    chk_out("B young first", 1'b1, 5, 8, 1'b1);
    chk("B young first issue_op", 32'(issue_op), 32'h65);
    issue_ready = 1'b1;
    tick();
    idle();
    chk_out("B before wake", 1'b1, 6, 9, 1'b1);
    wake_v = 2'b01; wake_tag[5:0] = 6'h15;
    tick();
    idle();
    chk_out("B older wins", 1'b1, 2, 9, 1'b1);
    chk("B older wins issue_prs1", 32'(issue_prs1), 32'h15);
    issue_ready = 1'b1;
    tick();
    chk_out("B then young", 1'b1, 6, 10, 1'b1);
    tick();
    chk_out("B stalled rest", 1'b0, 0, 11, 1'b1);
    idle(); flush = 1'b1; tick(); idle();
    chk_out("B flush", 1'b0, 0, 16, 1'b1);

    // Non-contiguous slot mask into scattered free entries {3,7,9,12}
    for (int g = 0; g < 4; g++) begin
      idle(); disp_valid = 1'b1; disp_v = 4'hF;
      for (int k = 0; k < 4; k++) begin
        logic r;
        r = (g == 0 && k == 3) || (g == 1 && k == 3) || (g == 2 && k == 1) || (g == 3 && k == 0);
        slot(k, 7'(112 + 4*g + k), 6'h3F, ~r, 0, 6'h0, 0, 0, 6'h0, 0);
      end
      tick();
    end
    idle(); issue_ready = 1'b1;
    chk_out("C pick3", 1'b1, 3, 0, 1'b0);  tick();
    chk_out("C pick7", 1'b1, 7, 1, 1'b0);  tick();
    chk_out("C pick9", 1'b1, 9, 2, 1'b0);  tick();
    chk_out("C pick12", 1'b1, 12, 3, 1'b0); tick();
    chk_out("C four free", 1'b0, 0, 4, 1'b1);
    disp_valid = 1'b1; disp_v = 4'b1010;
    slot(0, 7'h11, 6'h0, 0, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(1, 7'h21, 6'h0, 0, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(2, 7'h12, 6'h0, 0, 0, 6'h0, 0, 0, 6'h0, 0);
    slot(3, 7'h23, 6'h0, 0, 0, 6'h0, 0, 0, 6'h0, 0);
    tick();
    idle(); issue_ready = 1'b1;
    chk_out("C slot1", 1'b1, 3, 2, 1'b0);
    chk("C slot1 issue_op", 32'(issue_op), 32'h21);
    tick();
    chk_out("C slot3", 1'b1, 7, 3, 1'b0);
    chk("C slot3 issue_op", 32'(issue_op), 32'h23);
    tick();
    chk_out("C empty", 1'b0, 0, 4, 1'b1);
    idle(); flush = 1'b1; tick(); idle();
    chk_out("C flush", 1'b0, 0, 16, 1'b1);

    // Wake in the same cycle as dispatch of the matching source
    disp_valid = 1'b1; disp_v = 4'b0001;
    slot(0, 7'h31, 6'h21, 1, 0, 6'h0, 0, 0, 6'h0, 0);
    wake_v = 2'b10; wake_tag[11:6] = 6'h21;
    tick();
    idle();
    chk_out("D same-cycle wake", 1'b1, 0, 15, 1'b1);
    issue_ready = 1'b1;
    tick();
    idle();
    chk_out("D drained", 1'b0, 0, 16, 1'b1);
    disp_valid = 1'b1; disp_v = 4'hF; flush = 1'b1;
    for (int k = 0; k < 4; k++) slot(k, 7'h33, 6'h0, 0, 0, 6'h0, 0, 0, 6'h0, 0);
    tick();
    idle();
    chk_out("D flush beats dispatch", 1'b0, 0, 16, 1'b1);

    // Producer/consumer on tag 0x0A
    disp_valid = 1'b1; disp_v = 4'b0011;
    slot(0, 7'h40, 6'h0, 0, 0, 6'h0, 0, 0, 6'h0A, 1);
    slot(1, 7'h41, 6'h0A, 1, 0, 6'h0, 0, 0, 6'h0B, 1);
    tick();
    idle();
    chk_out("E producer", 1'b1, 0, 14, 1'b1);
    chk("E producer issue_prd", 32'(issue_prd), 32'h0A);
    issue_ready = 1'b1;
    tick();
    idle(); issue_ready = 1'b1;
`ifdef CIQ_ISSUE_WAKE_EN
    chk_out("E back-to-back", 1'b1, 1, 15, 1'b1);
    tick();
`else
    chk_out("E consumer stalled", 1'b0, 0, 15, 1'b1);
    wake_v = 2'b01; wake_tag[5:0] = 6'h0A;
    tick();
    idle(); issue_ready = 1'b1;
    chk_out("E consumer after wake", 1'b1, 1, 15, 1'b1);
    tick();
`endif
    idle();
    chk_out("E drained", 1'b0, 0, 16, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
